freq_hop_scheduler: RTL
=======================

# freq_hop_scheduler

Sequencer that drives one `freq_generator` instance through a programmable frequency-hopping schedule. It holds a small table of carrier words with per-slot dwell times and issues the generator's start and reset. It updates `f_c` at each hop; the generator accumulates phase, so hops are phase-continuous. It sits between the CPU-side register block and the `freq_generator`.

## Interface
Parameters:
- `ADDR_W`, default 3: slot address width; the table holds `2**ADDR_W` slots.
- `DWELL_W`, default 16: width of the per-slot dwell count, in clk cycles.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in `ADDR_W`: table slot to write.
- `cfg_fc` in 30: carrier word for the slot.
- `cfg_dwell` in `DWELL_W`: dwell for the slot, in clk cycles; 0 is treated as 1.
- `last_slot` in `ADDR_W`: index of the final slot in the schedule.
- `loop_en` in 1: after `last_slot`, wrap to slot 0 instead of stopping.
- `go` in 1: start-schedule pulse; used only in IDLE.
- `abort` in 1: stop the schedule from any non-IDLE state.
- `gen_active` in 1: `active` output from `freq_generator`.
- `gen_reset_n` out 1: drives `freq_generator` `reset_n` (synchronous in the generator).
- `gen_start` out 1: drives `freq_generator` `start`.
- `f_c` out 30: carrier word to `freq_generator`.
- `slot_idx` out `ADDR_W`: slot currently applied.
- `hop` out 1: one-cycle pulse when `f_c` changes to the next slot.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the schedule ends or is aborted.
- `err` out 1: sticky timeout flag; exists only with `FREQ_HOP_TIMEOUT_EN`.

## Operation
- The table is flops: a 30-bit word and a `DWELL_W`-bit dwell per slot.
  - A write with `cfg_we` takes effect on the next edge, in any state.
  - A slot's contents are sampled only when that slot is loaded. Rewriting the active slot does not affect `f_c` or the running dwell count.
- All outputs are registered.
- States:
  - IDLE: `gen_reset_n`=1. On `go`: `f_c`<=table[0].fc, `slot_idx`<=0, go to ARM.
  - ARM: `gen_start`=1 for exactly this cycle. Go to WAIT_ACT.
  - WAIT_ACT: wait for `gen_active`=1. Then load `cnt`<=max(dwell[slot],1)-1 and go to DWELL.
  - DWELL: `cnt` decrements each cycle. At `cnt`==0:
    - If `slot_idx`!=`last_slot`: next=`slot_idx`+1.
    - Else if `loop_en`: next=0.
    - Else go to STOP.
    - On a hop: `f_c`<=table[next].fc, `slot_idx`<=next, `hop`=1 for one cycle, `cnt`<=max(dwell[next],1)-1, stay in DWELL.
  - STOP: `gen_reset_n`=0 and `done`=1 for this one cycle. Go to IDLE.
- `abort` in ARM, WAIT_ACT or DWELL goes to STOP on the next edge. `abort` beats a same-cycle hop. `abort` in IDLE or STOP is ignored.
- `go` outside IDLE is ignored. `go` and `abort` together in IDLE: `go` wins.
- `last_slot` and `loop_en` are sampled live at each dwell expiry, so changes apply at the next hop decision.
- `slot_idx` increments wrap at `2**ADDR_W`. This only matters if `last_slot` is lowered below the current slot mid-run; the schedule then runs to the top slot, wraps, and stops at `last_slot`.

## Timing
- Reset values: `gen_reset_n`=0, `gen_start`=0, `f_c`=0, `slot_idx`=0, `hop`=0, `busy`=0, `done`=0, `err`=0, state IDLE. `gen_reset_n` rises on the first edge after reset release.
- `go` sampled at edge t:
  - `busy`=1 and `gen_start`=1 in cycle t+1.
  - `f_c` is valid from t+1.
- `gen_active` is first seen high at edge a. Slot 0 is then held for exactly max(dwell0,1) cycles before the `hop` cycle.
- Each later slot is held for exactly max(dwell,1) cycles. The `hop` pulse is coincident with the new `f_c`.
- Asserting `reset_n` mid-run clears all state immediately. `gen_reset_n`=0 holds the generator in reset.

## Configuration
- `FREQ_HOP_TIMEOUT_EN` defined:
  - WAIT_ACT has a 6-bit timeout counter.
  - If `gen_active` is not seen within 63 cycles, set `err`=1 and go to STOP.
  - `err` clears only on reset or on the next `go`.
- `FREQ_HOP_TIMEOUT_EN` undefined: WAIT_ACT waits indefinitely. `err` is tied to 0.

## Test plan
- Run/stop: slots 0/1/2 = fc 0x100/0x200/0x300, dwell 10/5/0, `last_slot`=2, `loop_en`=0, `go`, `gen_active` 3 cycles after `gen_start`. Expect:
  - `f_c` 0x100 held 10 cycles, 0x200 held 5, 0x300 held 1.
  - Two `hop` pulses, then `gen_reset_n`=0 and `done`=1 for one cycle, `busy`=0.
- Looping: `last_slot`=1, `loop_en`=1, dwell 4/4. Expect `slot_idx` 0,1,0,1… with a `hop` every 4 cycles and no `done`.
- Abort on expiry: `abort` in the same cycle as a dwell expiry. Expect no `hop`, STOP next cycle, `done`=1, `f_c` unchanged.
- Live write: rewrite slot 1 fc to 0x555 while slot 1 is active. Expect `f_c` unchanged; 0x555 appears on the next visit to slot 1 with `loop_en`=1.
- Async reset mid-DWELL: pull `reset_n` low. Expect all outputs at their reset values immediately and `gen_reset_n`=0.
- With `FREQ_HOP_TIMEOUT_EN` defined: hold `gen_active`=0 after `go`. Expect `err`=1 and `done`=1 63 cycles after ARM. A new `go` clears `err`.

Source files
------------

// File: rtl/freq_hop_scheduler.sv
// freq_hop_scheduler
//   Steps one freq_generator through a table of (carrier word, dwell) slots.
//   The generator accumulates phase, so changing f_c at a hop keeps the
//   output phase-continuous. All outputs are registered.
//
//   Optional feature macro: FREQ_HOP_TIMEOUT_EN
//     defined   : WAIT_ACT gives up after a bounded wait for gen_active,
//                 raises the sticky err flag and ends the schedule.
//     undefined : WAIT_ACT waits forever, err is tied low.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   cfg_we/addr/fc/dwell table write port (any state, effective next edge)
//   last_slot, loop_en  schedule end / wrap control, sampled at each expiry
//   go, abort           start (IDLE only) / stop (ARM, WAIT_ACT, DWELL)
//   gen_active          generator running indication
//   gen_reset_n         generator reset (low for the single STOP cycle)
//   gen_start           generator start (high for the single ARM cycle)
//   f_c, slot_idx       applied carrier word and its slot
//   hop                 one-cycle pulse coincident with a new f_c
//   busy, done          not-IDLE level / end-of-schedule pulse
//   err                 sticky activation timeout flag
module freq_hop_scheduler #(
   parameter int ADDR_W  = 3,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_we,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [29:0]        cfg_fc,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [ADDR_W-1:0]  last_slot,
   input  logic               loop_en,
   input  logic               go,
   input  logic               abort,
   input  logic               gen_active,
   output logic               gen_reset_n,
   output logic               gen_start,
   output logic [29:0]        f_c,
   output logic [ADDR_W-1:0]  slot_idx,
   output logic               hop,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int SLOTS = 2**ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_ACT,
      S_DWELL,
      S_STOP
   } state_e;

   state_e state_q, state_d;

   logic [SLOTS-1:0][29:0]        fc_tab_q;
   logic [SLOTS-1:0][DWELL_W-1:0] dw_tab_q;

   logic [29:0]        f_c_q, fc_d;
   logic [ADDR_W-1:0]  slot_q, slot_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               hop_q, hop_d;
   logic               gen_reset_n_q, gen_start_q, busy_q, done_q;

   logic [ADDR_W-1:0]  next_slot;
   logic               sched_end;

   // Dwell of 0 behaves as 1; cnt counts down to 0 inclusive.
   function automatic logic [DWELL_W-1:0] dwell_m1(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - DWELL_W'(1);
   endfunction

   // Table flops. A load samples the table before a same-edge write lands,
   // so rewriting the active slot never disturbs the running slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fc_tab_q <= '0;
         dw_tab_q <= '0;
      end else if (cfg_we) begin
         fc_tab_q[cfg_addr] <= cfg_fc;
         dw_tab_q[cfg_addr] <= cfg_dwell;
      end
   end

   // Increment wraps at 2**ADDR_W, so lowering last_slot below the current
   // slot runs to the top slot, wraps, and stops at last_slot.
   assign next_slot = (slot_q != last_slot) ? slot_q + ADDR_W'(1) : '0;
   assign sched_end = (slot_q == last_slot) && !loop_en;

`ifdef FREQ_HOP_TIMEOUT_EN
   // Counts ARM then WAIT_ACT cycles; giving up at 62 puts STOP (done, err)
   // exactly 63 cycles after the ARM cycle.
   localparam logic [5:0] TO_LIMIT = 6'd62;
   logic [5:0] to_q, to_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      fc_d    = f_c_q;
      slot_d  = slot_q;
      cnt_d   = cnt_q;
      hop_d   = 1'b0;
`ifdef FREQ_HOP_TIMEOUT_EN
      to_d    = 6'd0;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            // go wins over a simultaneous abort: abort is not looked at here
            if (go) begin
               fc_d    = fc_tab_q[0];
               slot_d  = '0;
               state_d = S_ARM;
`ifdef FREQ_HOP_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_ARM: begin
`ifdef FREQ_HOP_TIMEOUT_EN
            to_d = to_q + 6'd1;
`endif
            state_d = abort ? S_STOP : S_WAIT_ACT;
         end
         S_WAIT_ACT: begin
            if (abort) begin
               state_d = S_STOP;
            end else if (gen_active) begin
               cnt_d   = dwell_m1(dw_tab_q[slot_q]);
               state_d = S_DWELL;
            end
`ifdef FREQ_HOP_TIMEOUT_EN
            else if (to_q == TO_LIMIT) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else begin
               to_d = to_q + 6'd1;
            end
`endif
         end
         S_DWELL: begin
            // abort has priority over a hop in the same cycle
            if (abort) begin
               state_d = S_STOP;
            end else if (cnt_q == '0) begin
               if (sched_end) begin
                  state_d = S_STOP;
               end else begin
                  fc_d   = fc_tab_q[next_slot];
                  slot_d = next_slot;
                  cnt_d  = dwell_m1(dw_tab_q[next_slot]);
                  hop_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_STOP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state
   // they describe (busy/gen_start in the cycle after go, etc.).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         f_c_q         <= '0;
         slot_q        <= '0;
         cnt_q         <= '0;
         hop_q         <= 1'b0;
         gen_reset_n_q <= 1'b0;
         gen_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         f_c_q         <= fc_d;
         slot_q        <= slot_d;
         cnt_q         <= cnt_d;
         hop_q         <= hop_d;
         gen_reset_n_q <= (state_d != S_STOP);
         gen_start_q   <= (state_d == S_ARM);
         busy_q        <= (state_d != S_IDLE);
         done_q        <= (state_d == S_STOP);
      end
   end

`ifdef FREQ_HOP_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_q  <= 6'd0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign gen_reset_n = gen_reset_n_q;
   assign gen_start   = gen_start_q;
   assign f_c         = f_c_q;
   assign slot_idx    = slot_q;
   assign hop         = hop_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
